// File: rtl/seq_div_pkg.sv
// Shared types and widths for the sequential 16/8 unsigned divider.
package seq_div_pkg;

    localparam int DIVIDEND_W = 16;
    localparam int DIVISOR_W  = 8;
    localparam int QUOT_W     = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit,
// subtract the divisor when it fits, and shift the resulting quotient bit into Q.
module div_step
    import seq_div_pkg::*;
(
    input  logic [QUOT_W-1:0] r_in,
    input  logic [QUOT_W-1:0] q_in,
    input  logic [QUOT_W-1:0] d,
    output logic [QUOT_W-1:0] r_out,
    output logic [QUOT_W-1:0] q_out
);

    logic [QUOT_W:0] t;
    logic [QUOT_W:0] diff;
    logic            qbit;

    // NOTE: combinational logic uses blocking '=' so later lines see earlier results.
    always_comb begin
        t     = {r_in, q_in[QUOT_W-1]};
        diff  = t - {1'b0, d};
        qbit  = (t >= {1'b0, d});
        r_out = qbit ? diff[QUOT_W-1:0] : t[QUOT_W-1:0];
        q_out = {q_in[QUOT_W-2:0], qbit};
    end

endmodule

// File: rtl/seq_div16u8.sv
// Sequential 16/8 unsigned restoring divider resolving BITS_PER_CYCLE quotient bits per clock.
// Define SEQ_DIV_OVF_CHECK_EN to flag quotient overflow / divide-by-zero up front.
module seq_div16u8
    import seq_div_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [QUOT_W-1:0]     quotient,
    output logic [QUOT_W-1:0]     remainder,
    output logic                  ovf
);

    localparam int N_STEPS = QUOT_W / BITS_PER_CYCLE;
    localparam int CNT_W   = 4;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N_STEPS - 1);

    if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2 &&
        BITS_PER_CYCLE != 4 && BITS_PER_CYCLE != 8) begin : g_bad_param
        $error("seq_div16u8: BITS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    state_t               state, state_next;
    logic [QUOT_W-1:0]    r_q, q_q, d_q;
    logic [CNT_W-1:0]     cnt;
    logic                 ovf_q;
    logic                 ovf_hit;

    logic [QUOT_W-1:0]    r_chain [BITS_PER_CYCLE+1];
    logic [QUOT_W-1:0]    q_chain [BITS_PER_CYCLE+1];

`ifdef SEQ_DIV_OVF_CHECK_EN
    // High byte not below the divisor means the quotient needs more than 8 bits.
    assign ovf_hit = (dividend[DIVIDEND_W-1 -: QUOT_W] >= divisor);
`else
    assign ovf_hit = 1'b0;
`endif

    assign r_chain[0] = r_q;
    assign q_chain[0] = q_q;

    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
        div_step u_step (
            .r_in  (r_chain[i]),
            .q_in  (q_chain[i]),
            .d     (d_q),
            .r_out (r_chain[i+1]),
            .q_out (q_chain[i+1])
        );
    end

    // NOTE: next state defaults to the current state first, so no path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)         state_next = ovf_hit ? DONE : BUSY;
            BUSY:    if (cnt == LAST_STEP) state_next = DONE;
            DONE:    if (out_ready)        state_next = IDLE;
            default:                       state_next = IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking '<=' so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q   <= '0;
            q_q   <= '0;
            d_q   <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cnt <= '0;
                        d_q <= divisor;
                        if (ovf_hit) begin
                            r_q   <= '1;
                            q_q   <= '1;
                            ovf_q <= 1'b1;
                        end else begin
                            r_q   <= dividend[DIVIDEND_W-1 -: QUOT_W];
                            q_q   <= dividend[QUOT_W-1:0];
                            ovf_q <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    r_q <= r_chain[BITS_PER_CYCLE];
                    q_q <= q_chain[BITS_PER_CYCLE];
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign quotient  = q_q;
    assign remainder = r_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/seq_div16u8.md
SEQ_DIV16U8 -- requirements
Module: seq_div16u8

Interface
REQ-001 Parameter: BITS_PER_CYCLE, default 1, quotient bits resolved per clock; legal values 1, 2, 4, 8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  dividend/divisor valid.
REQ-005 in_ready  output  1  block can accept an operation.
REQ-006 dividend  input  16  unsigned dividend.
REQ-007 divisor  input  8  unsigned divisor.
REQ-008 out_valid  output  1  result valid.
REQ-009 out_ready  input  1  consumer takes result.
REQ-010 quotient  output  8  unsigned quotient.
REQ-011 remainder  output  8  unsigned remainder.
REQ-012 ovf  output  1  quotient does not fit 8 bits, or divide-by-zero (see Configuration).

Function
REQ-013 States IDLE, BUSY, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-014 Accept on edge with in_valid && in_ready: load R = dividend[15:8], Q = dividend[7:0], D = divisor, step counter = 0, go BUSY.
REQ-015 One iteration: T = {R, Q[7]} (9 bits); if T >= {0,D} then R = (T-D)[7:0], qbit = 1, else R = T[7:0], qbit = 0; Q = {Q[6:0], qbit}.
REQ-016 BUSY performs BITS_PER_CYCLE chained iterations per edge; after N = 8/BITS_PER_CYCLE edges go DONE, so out_valid rises exactly N edges after the accepting edge.
REQ-017 quotient = Q, remainder = R; both held stable and unchanged while out_valid && !out_ready.
REQ-018 DONE with out_ready: return to IDLE on that edge; next accept no earlier than following edge (no overlap, one operation in flight).
REQ-019 in_valid during BUSY/DONE ignored; inputs sampled only at accept.
REQ-020 Divisor 0 without overflow check follows REQ-015 unmodified (yields quotient 0xFF, remainder = dividend[7:0]).

Reset
REQ-021 rst forces IDLE, counter 0, quotient 0, remainder 0, ovf 0, out_valid 0, in_ready 1 on next edge.
REQ-022 rst mid-BUSY or in DONE aborts the operation; result discarded, no out_valid.
REQ-023 rst has priority over accept and handshake in the same cycle.

Configuration
REQ-024 Macro SEQ_DIV_OVF_CHECK_EN compiles in overflow detection.
REQ-025 Defined: at accept, if dividend[15:8] >= divisor (includes divisor 0), skip BUSY, go DONE on the accepting edge with quotient 0xFF, remainder 0xFF, ovf 1; out_valid one edge after accept.
REQ-026 Defined: non-overflow operations identical to REQ-014..REQ-018 with ovf 0.
REQ-027 Not defined: ovf tied 0; all operations follow REQ-015 and take N edges; port list unchanged.

Structure
REQ-028 Package seq_div_pkg holds state enum (IDLE, BUSY, DONE), DIVIDEND_W = 16, DIVISOR_W = 8, QUOT_W = 8.
REQ-029 Sub-module div_step: combinational single restoring iteration (R, Q, D in; R, Q out), instantiated BITS_PER_CYCLE times in a chain.

Verification
REQ-030 0x1234 / 0x56, BITS_PER_CYCLE=1 -> out_valid 8 edges after accept, quotient 0x36, remainder 0x10, ovf 0.
REQ-031 0xFEFF / 0xFF, BITS_PER_CYCLE=4 -> out_valid 2 edges after accept, quotient 0xFF, remainder 0xFE.
REQ-032 0x5600 / 0x56 -> macro defined: out_valid 1 edge after accept, quotient 0xFF, remainder 0xFF, ovf 1; undefined: 8 edges, ovf 0, REQ-015 model result.
REQ-033 0x00FF / 0x00 -> macro undefined: quotient 0xFF, remainder 0xFF, ovf 0; defined: ovf 1.
REQ-034 out_ready low 5 cycles after out_valid -> result stable, in_ready 0, new in_valid ignored; out_ready high -> IDLE next edge.
REQ-035 rst pulse at BUSY step 4 -> IDLE next edge, outputs 0, no out_valid; following 0x0064 / 0x07 -> quotient 0x0E, remainder 0x02.
